// File: rtl/traffic_sensor_timer_pkg.sv
// Shared types and defaults for the traffic-light sensor/phase-timer stage.
// Phase codes match the light FSM's encoding.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_RED    = 2'b10,
        PH_NONE   = 2'b11
    } phase_t;

    typedef enum logic [1:0] {
        S_WAIT  = 2'b00,
        S_READY = 2'b01,
        S_REQ   = 2'b10
    } state_t;

    localparam int DEF_DEB_CYCLES    = 4;
    localparam int DEF_GREEN_CYCLES  = 20;
    localparam int DEF_YELLOW_CYCLES = 5;
    localparam int DEF_RED_CYCLES    = 15;
    localparam int DEF_CNT_W         = 8;

    // Anything other than exactly one lamp lit is not a usable phase.
    function automatic phase_t decode_phase(logic green, logic yellow, logic red);
        case ({green, yellow, red})
            3'b100:  return PH_GREEN;
            3'b010:  return PH_YELLOW;
            3'b001:  return PH_RED;
            default: return PH_NONE;
        endcase
    endfunction

    // A zero duration would never expire, so it behaves as one clock.
    function automatic int eff_dur(int d);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/traffic_sensor_timer_if.sv
// Signal bundle between the light FSM side (master) and the sensor/timer stage (slave).
interface traffic_sensor_timer_if;
    logic SENSOR;
    logic GREEN;
    logic YELLOW;
    logic RED;
    logic CAR;
    logic TIMEOUT;
    logic CAR_PRESENT;

    modport master (
        output SENSOR, GREEN, YELLOW, RED,
        input  CAR, TIMEOUT, CAR_PRESENT
    );

    modport slave (
        input  SENSOR, GREEN, YELLOW, RED,
        output CAR, TIMEOUT, CAR_PRESENT
    );
endinterface

// File: rtl/traffic_sensor_timer_debounce.sv
// Two-flop synchronizer plus consecutive-mismatch debounce for the raw car sensor.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic Clock,
    input  logic Reset,
    input  logic sensor,
    output logic car_present
);

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic       sync1;
    logic       sens_s;
    logic [7:0] dcnt;

    // NOTE: non-blocking (<=) so every flop updates together from pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1       <= 1'b0;
            sens_s      <= 1'b0;
            dcnt        <= '0;
            car_present <= 1'b0;
        end else begin
            sync1  <= sensor;
            sens_s <= sync1;
            if (sens_s == car_present) begin
                dcnt <= '0;
            end else if (dcnt == DEB_LAST) begin
                car_present <= ~car_present;
                dcnt        <= '0;
            end else begin
                dcnt <= dcnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/traffic_sensor_timer.sv
// Conditions the car sensor and times each light phase, producing CAR and TIMEOUT
// for the light FSM from the fed-back lamp state.
module traffic_sensor_timer
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
    parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
    parameter int RED_CYCLES    = DEF_RED_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                         Clock,
    input  logic                         Reset,
    traffic_sensor_timer_if.slave        io
);

    // Timer value on the edge before expiry; expiry then lands exactly on edge L.
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(eff_dur(GREEN_CYCLES) - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(eff_dur(YELLOW_CYCLES) - 1);
    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(eff_dur(RED_CYCLES) - 1);

    phase_t           ph;
    phase_t           prev_ph;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] last;
    logic             ph_change;
    logic             ph_valid;
    logic             at_limit;
    logic             car_present;
    logic             car_d;
    logic             timeout_d;
    logic             car_q;
    logic             timeout_q;

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
        .Clock       (Clock),
        .Reset       (Reset),
        .sensor      (io.SENSOR),
        .car_present (car_present)
    );

    assign ph        = decode_phase(io.GREEN, io.YELLOW, io.RED);
    assign ph_change = (ph != prev_ph);
    assign ph_valid  = (ph != PH_NONE);
    assign at_limit  = (timer == last);

    always_comb begin
        last = GREEN_LAST;
        case (ph)
            PH_YELLOW: last = YELLOW_LAST;
            PH_RED:    last = RED_LAST;
            default:   last = GREEN_LAST;
        endcase
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        car_d     = 1'b0;
        if (ph_change || !ph_valid) begin
            state_nxt = S_WAIT;
        end else begin
            case (state)
                S_WAIT:  if (at_limit) state_nxt = S_READY;
                S_READY: begin
                    // Green holds until a car is waiting; yellow and red advance on time.
                    if (ph != PH_GREEN || car_present) begin
                        state_nxt = S_REQ;
                        car_d     = 1'b1;
                    end
                end
                S_REQ:   state_nxt = S_REQ;
                default: state_nxt = S_WAIT;
            endcase
        end
        timeout_d = (state_nxt != S_WAIT);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            prev_ph   <= PH_NONE;
            timer     <= '0;
            state     <= S_WAIT;
            car_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            prev_ph   <= ph;
            state     <= state_nxt;
            car_q     <= car_d;
            timeout_q <= timeout_d;
            if (ph_change || !ph_valid) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + CNT_W'(1);
            end
        end
    end

    assign io.CAR         = car_q;
    assign io.TIMEOUT     = timeout_q;
    assign io.CAR_PRESENT = car_present;

endmodule

// File: tb/tb_traffic_sensor_timer.sv
// Directed scenarios plus randomized lamp/sensor traffic, checked every cycle against
// an occupancy-based reference model of the sensor/phase-timer stage.
module tb_traffic_sensor_timer;

    localparam int DEB = 4;
    localparam int GD  = 20;
    localparam int YD  = 5;
    localparam int RD  = 15;
    localparam int PH_N = 3;

    logic Clock = 1'b0;
    logic Reset;

    traffic_sensor_timer_if io ();

    traffic_sensor_timer dut (
        .Clock (Clock),
        .Reset (Reset),
        .io    (io)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Reference model state: phase occupancy, not counters.
    int m_prev_ph;
    int m_entry;
    bit m_car_done;
    bit m_cp;
    int m_run;
    bit hist[$];

    // Event trackers relative to a scenario's cycle 0.
    int mark;
    int to_rise;
    int car_cnt;
    int car_at;
    int cp_at;
    logic cp_last;

    task automatic check(string tag, logic observed, logic expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b at edge %0d", tag, observed, expected, edge_n);
        end
    endtask

    task automatic check_int(string tag, int observed, int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int lamp_phase(logic g, logic y, logic r);
        if ($countones({g, y, r}) != 1) return PH_N;
        if (g) return 0;
        if (y) return 1;
        return 2;
    endfunction

    function automatic int dur_of(int ph);
        case (ph)
            0:       return GD;
            1:       return YD;
            default: return RD;
        endcase
    endfunction

    task automatic model_reset();
        m_prev_ph  = PH_N;
        m_entry    = 0;
        m_car_done = 1'b0;
        m_cp       = 1'b0;
        m_run      = 0;
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
    endtask

    task automatic track(int m);
        mark    = m;
        to_rise = -1;
        car_cnt = 0;
        car_at  = -1;
        cp_at   = -1;
        cp_last = io.CAR_PRESENT;
    endtask

    task automatic set_lamps(logic g, logic y, logic r);
        io.GREEN  = g;
        io.YELLOW = y;
        io.RED    = r;
    endtask

    task automatic step();
        int ph;
        int lim;
        int el;
        bit s;
        bit exp_to;
        bit exp_car;
        @(posedge Clock);
        edge_n++;
        ph = lamp_phase(io.GREEN, io.YELLOW, io.RED);
        if (ph != m_prev_ph) begin
            m_entry    = edge_n;
            m_car_done = 1'b0;
        end
        m_prev_ph = ph;
        el  = edge_n - m_entry;
        lim = (dur_of(ph) < 1) ? 1 : dur_of(ph);
        exp_to  = (ph != PH_N) && (el >= lim);
        exp_car = (ph != PH_N) && (el >= lim + 1) && !m_car_done && (ph != 0 || m_cp);
        if (exp_car) m_car_done = 1'b1;
        // The debouncer sees the sensor as sampled two edges earlier.
        s = hist[0];
        hist.push_back(io.SENSOR);
        void'(hist.pop_front());
        if (s != m_cp) begin
            m_run++;
            if (m_run == DEB) begin
                m_cp  = !m_cp;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        #1;
        check("TIMEOUT", io.TIMEOUT, exp_to);
        check("CAR", io.CAR, exp_car);
        check("CAR_PRESENT", io.CAR_PRESENT, m_cp);
        if (io.TIMEOUT === 1'b1 && to_rise < 0) to_rise = edge_n - mark;
        if (io.CAR === 1'b1) begin
            car_cnt++;
            car_at = edge_n - mark;
        end
        if (io.CAR_PRESENT !== cp_last && cp_at < 0) cp_at = edge_n - mark;
        cp_last = io.CAR_PRESENT;
    endtask

    task automatic async_reset_check(string tag);
        #2;
        Reset = 1'b0;
        #1;
        check({tag, "_car"}, io.CAR, 1'b0);
        check({tag, "_timeout"}, io.TIMEOUT, 1'b0);
        check({tag, "_car_present"}, io.CAR_PRESENT, 1'b0);
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset     = 1'b0;
        io.SENSOR = 1'b0;
        set_lamps(1'b0, 1'b0, 1'b0);
        model_reset();
        track(0);
        repeat (3) @(posedge Clock);
        #2;
        check("rst_car", io.CAR, 1'b0);
        check("rst_timeout", io.TIMEOUT, 1'b0);
        check("rst_car_present", io.CAR_PRESENT, 1'b0);
        Reset = 1'b1;

        // Green with a car already waiting, then reset mid-phase.
        set_lamps(1'b1, 1'b0, 1'b0);
        io.SENSOR = 1'b1;
        track(edge_n + 1);
        repeat (25) step();
        check_int("green_car_timeout_rise", to_rise, 20);
        check_int("green_car_pulse_cycle", car_at, 21);
        async_reset_check("midphase_rst");
        set_lamps(1'b0, 1'b1, 1'b0);
        io.SENSOR = 1'b0;
        Reset = 1'b1;
        track(edge_n + 1);
        repeat (8) step();
        check_int("post_rst_yellow_rise", to_rise, 5);

        // Bounce faster than the debounce window, then a clean edge.
        set_lamps(1'b0, 1'b0, 1'b0);
        track(edge_n);
        for (int i = 0; i < 40; i++) begin
            io.SENSOR = ((i % 4) < 2);
            step();
        end
        check_int("bounce_no_change", cp_at, -1);
        io.SENSOR = 1'b1;
        track(edge_n);
        repeat (10) step();
        check_int("debounce_latency", cp_at, 6);

        // Green with no car waits; a car at cycle 50 releases one pulse.
        io.SENSOR = 1'b0;
        repeat (8) step();
        set_lamps(1'b1, 1'b0, 1'b0);
        track(edge_n + 1);
        while (edge_n - mark < 50) step();
        check_int("green_nocar_rise", to_rise, 20);
        check_int("green_nocar_pulses", car_cnt, 0);
        io.SENSOR = 1'b1;
        repeat (10) step();
        check_int("green_late_car_pulses", car_cnt, 1);
        check_int("green_late_car_cycle", car_at, 57);

        // Yellow advances on time only, once per occupancy.
        set_lamps(1'b0, 1'b1, 1'b0);
        io.SENSOR = 1'b0;
        track(edge_n + 1);
        repeat (36) step();
        check_int("yellow_rise", to_rise, 5);
        check_int("yellow_pulses", car_cnt, 1);
        check_int("yellow_pulse_cycle", car_at, 6);
        check("yellow_timeout_held", io.TIMEOUT, 1'b1);

        // Phase change on the expiry edge wins.
        set_lamps(1'b0, 1'b0, 1'b0);
        step();
        set_lamps(1'b0, 1'b1, 1'b0);
        track(edge_n + 1);
        while (edge_n - mark < 4) step();
        set_lamps(1'b0, 1'b0, 1'b1);
        step();
        check("prio_no_timeout", io.TIMEOUT, 1'b0);
        check_int("prio_yellow_never_expired", to_rise, -1);
        track(edge_n);
        repeat (20) step();
        check_int("prio_red_rise", to_rise, 15);

        // Non-one-hot lamps hold everything idle.
        set_lamps(1'b1, 1'b0, 1'b1);
        track(edge_n + 1);
        repeat (40) step();
        check_int("invalid_timeout", to_rise, -1);
        check_int("invalid_car", car_cnt, 0);
        set_lamps(1'b0, 1'b0, 1'b1);
        track(edge_n + 1);
        repeat (20) step();
        check_int("red_after_invalid_rise", to_rise, 15);
        check_int("red_after_invalid_pulses", car_cnt, 1);

        // Randomized lamp and sensor traffic with one reset in the middle.
        for (int seg = 0; seg < 60; seg++) begin
            int hold;
            logic [2:0] lamps;
            if ($urandom_range(0, 9) < 7) lamps = 3'b001 << $urandom_range(0, 2);
            else lamps = 3'($urandom_range(0, 7));
            set_lamps(lamps[2], lamps[1], lamps[0]);
            hold = $urandom_range(1, 40);
            for (int c = 0; c < hold; c++) begin
                if ($urandom_range(0, 5) == 0) io.SENSOR = 1'($urandom_range(0, 1));
                step();
            end
            if (seg == 30) begin
                async_reset_check("rand_rst");
                Reset = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
